pipeline_mem_arbiter: RTL and testbench

Arbiter and sequencer for the single unified memory port of the pipelined RV32I core. Shares the port between the IF-stage instruction fetch and the MEM-stage load/store driven from the EX/MEM register outputs (ALU result address, write data, byte select, funct3). Runs one outstanding bus transaction at a time and returns per-requester completion strobes. The core derives its stall signals from those strobes.

---
 rtl/pipeline_mem_arbiter_pkg.sv | 66 ++++++
 rtl/pipeline_mem_arbiter_mem_load_align.sv | 25 ++
 rtl/pipeline_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_pipeline_mem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_mem_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// XLEN defaults to 32 unless the build already provides `XLEN.
`ifndef XLEN
`define XLEN 32
`endif

package pipeline_mem_arbiter_pkg;

    localparam int XLEN     = `XLEN;
    localparam int STARVE_W = 4;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_e;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [3:0]      be;
    } bus_req_t;

    // Loads always read the whole aligned word; the byte lanes are picked later.
    function automatic bus_req_t dm_bus_req(
        input logic            we,
        input logic [XLEN-1:0] addr,
        input logic [XLEN-1:0] wdata,
        input logic [3:0]      byte_sel
    );
        bus_req_t r;
        r.we = we;
        if (we) begin
            r.addr  = addr;
            r.wdata = wdata;
            r.be    = byte_sel;
        end else begin
            r.addr  = {addr[XLEN-1:2], 2'b00};
            r.wdata = '0;
            r.be    = 4'hF;
        end
        return r;
    endfunction

    function automatic bus_req_t if_bus_req(input logic [XLEN-1:0] addr);
        bus_req_t r;
        r.we    = 1'b0;
        r.addr  = addr;
        r.wdata = '0;
        r.be    = 4'hF;
        return r;
    endfunction

endpackage

// File: rtl/pipeline_mem_arbiter_mem_load_align.sv
// Load data aligner: shifts the addressed lane down and sign/zero-extends by funct3.
// Only instantiated when MEMARB_LOAD_EXT_EN is defined.
module mem_load_align
    import pipeline_mem_arbiter_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      offset_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] rdata_o
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rdata_i >> {offset_i, 3'b000};
        case (funct3_i)
            F3_LB:   rdata_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_LH:   rdata_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_LBU:  rdata_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_LHU:  rdata_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: rdata_o = shifted;
        endcase
    end

endmodule

// File: rtl/pipeline_mem_arbiter.sv
// Arbiter/sequencer sharing one memory port between IF fetch and MEM load/store.
// Define MEMARB_LOAD_EXT_EN to align and extend load data here instead of in writeback.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transaction; pick owner and latch bus fields on request
// REQ     | o_bus_valid high, fields frozen until i_bus_ready
// RESP    | waiting for i_bus_rvalid; owner strobe fires in that cycle
module pipeline_mem_arbiter
    import pipeline_mem_arbiter_pkg::*;
#(
    parameter int IF_STARVE_MAX = 4
) (
    input  logic            i_clk,
    input  logic            i_rstn,

    input  logic            i_if_req,
    input  logic [XLEN-1:0] i_if_addr,
    output logic            o_if_rvalid,
    output logic [XLEN-1:0] o_if_rdata,
    output logic            o_stall_if,

    input  logic            i_dm_req,
    input  logic            i_dm_we,
    input  logic [XLEN-1:0] i_dm_addr,
    input  logic [XLEN-1:0] i_dm_wdata,
    input  logic [3:0]      i_dm_byte_sel,
    input  logic [2:0]      i_dm_funct3,
    output logic            o_dm_done,
    output logic [XLEN-1:0] o_dm_rdata,
    output logic            o_stall_mem,

    output logic            o_bus_valid,
    input  logic            i_bus_ready,
    output logic            o_bus_we,
    output logic [XLEN-1:0] o_bus_addr,
    output logic [XLEN-1:0] o_bus_wdata,
    output logic [3:0]      o_bus_be,
    input  logic            i_bus_rvalid,
    input  logic [XLEN-1:0] i_bus_rdata
);

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(IF_STARVE_MAX);

    arb_state_e          state_q;
    arb_owner_e          owner_q;
    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_d;
    logic                bus_valid_q;
    bus_req_t            bus_q;
    bus_req_t            grant_req_d;

    logic starve_hit;
    logic grant_dm;
    logic grant_if;
    logic resp_done;

    // Data normally wins; a fetch that has been overtaken IF_STARVE_MAX times goes next.
    always_comb begin
        starve_hit = i_if_req && (starve_q == STARVE_MAX);
        grant_dm   = i_dm_req && !starve_hit;
        grant_if   = i_if_req && !grant_dm;

        starve_d = starve_q;
        if (grant_dm) begin
            if (!i_if_req) begin
                starve_d = '0;
            end else if (starve_q != STARVE_MAX) begin
                starve_d = starve_q + 1'b1;
            end
        end else if (grant_if) begin
            starve_d = '0;
        end

        if (grant_dm) begin
            grant_req_d = dm_bus_req(i_dm_we, i_dm_addr, i_dm_wdata, i_dm_byte_sel);
        end else begin
            grant_req_d = if_bus_req(i_if_addr);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            starve_q    <= '0;
            bus_valid_q <= 1'b0;
            bus_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_dm || grant_if) begin
                        owner_q     <= grant_dm ? OWN_DM : OWN_IF;
                        bus_q       <= grant_req_d;
                        bus_valid_q <= 1'b1;
                        starve_q    <= starve_d;
                        state_q     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (i_bus_ready) begin
                        bus_valid_q <= 1'b0;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (i_bus_rvalid) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    bus_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    // Responses outside RESP are ignored, which also covers the aftermath of a reset.
    assign resp_done   = (state_q == ST_RESP) && i_bus_rvalid;
    assign o_if_rvalid = resp_done && (owner_q == OWN_IF);
    assign o_dm_done   = resp_done && (owner_q == OWN_DM);
    assign o_stall_if  = i_if_req && !o_if_rvalid;
    assign o_stall_mem = i_dm_req && !o_dm_done;
    assign o_if_rdata  = i_bus_rdata;

    assign o_bus_valid = bus_valid_q;
    assign o_bus_we    = bus_q.we;
    assign o_bus_addr  = bus_q.addr;
    assign o_bus_wdata = bus_q.wdata;
    assign o_bus_be    = bus_q.be;

`ifdef MEMARB_LOAD_EXT_EN
    mem_load_align u_load_align (
        .rdata_i  (i_bus_rdata),
        .offset_i (i_dm_addr[1:0]),
        .funct3_i (i_dm_funct3),
        .rdata_o  (o_dm_rdata)
    );
`else
    logic unused_funct3;
    assign unused_funct3 = ^i_dm_funct3;
    assign o_dm_rdata    = i_bus_rdata;
`endif

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Self-checking bench for pipeline_mem_arbiter: directed vector table, corner sequences
// and a randomized run against a transaction-level arbitration model.
module tb_pipeline_mem_arbiter;
    import pipeline_mem_arbiter_pkg::*;

    localparam int STARVE = 4;

    logic        i_clk, i_rstn;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_rvalid;
    logic [31:0] o_if_rdata;
    logic        o_stall_if;
    logic        i_dm_req, i_dm_we;
    logic [31:0] i_dm_addr, i_dm_wdata;
    logic [3:0]  i_dm_byte_sel;
    logic [2:0]  i_dm_funct3;
    logic        o_dm_done;
    logic [31:0] o_dm_rdata;
    logic        o_stall_mem;
    logic        o_bus_valid, i_bus_ready, o_bus_we;
    logic [31:0] o_bus_addr, o_bus_wdata;
    logic [3:0]  o_bus_be;
    logic        i_bus_rvalid;
    logic [31:0] i_bus_rdata;

    pipeline_mem_arbiter #(.IF_STARVE_MAX(STARVE)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_rvalid(o_if_rvalid),
        .o_if_rdata(o_if_rdata), .o_stall_if(o_stall_if),
        .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_addr(i_dm_addr),
        .i_dm_wdata(i_dm_wdata), .i_dm_byte_sel(i_dm_byte_sel), .i_dm_funct3(i_dm_funct3),
        .o_dm_done(o_dm_done), .o_dm_rdata(o_dm_rdata), .o_stall_mem(o_stall_mem),
        .o_bus_valid(o_bus_valid), .i_bus_ready(i_bus_ready), .o_bus_we(o_bus_we),
        .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata), .o_bus_be(o_bus_be),
        .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Expected load result from byte/halfword arithmetic on the returned word.
    function automatic logic [31:0] load_model(input logic [31:0] w, input logic [1:0] off,
                                               input logic [2:0] f3);
        longint v, b, h;
        v = longint'(w) >> (8 * int'(off));
        b = v & 255;
        h = v & 65535;
        case (f3)
            3'b000:  return (b >= 128)   ? 32'(b - 256)   : 32'(b);
            3'b001:  return (h >= 32768) ? 32'(h - 65536) : 32'(h);
            3'b100:  return 32'(b);
            3'b101:  return 32'(h);
            default: return 32'(v);
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] f3);
`ifdef MEMARB_LOAD_EXT_EN
        return load_model(w, off, f3);
`else
        return w;
`endif
    endfunction

    task automatic set_fetch(input logic [31:0] a);
        i_if_req  = 1'b1;
        i_if_addr = a;
    endtask

    task automatic set_dm(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] bs, input logic [2:0] f3);
        i_dm_req      = 1'b1;
        i_dm_we       = we;
        i_dm_addr     = a;
        i_dm_wdata    = wd;
        i_dm_byte_sel = bs;
        i_dm_funct3   = f3;
    endtask

    task automatic clear_dm();
        i_dm_req = 1'b0; i_dm_we = 1'b0; i_dm_addr = '0;
        i_dm_wdata = '0; i_dm_byte_sel = '0; i_dm_funct3 = '0;
    endtask

    // Called mid-cycle in IDLE with requests applied; acts as the bus slave for one transaction.
    task automatic serve(input string tag, input bit exp_dm, input logic [31:0] e_addr,
                         input logic e_we, input logic [3:0] e_be, input bit chk_wd,
                         input logic [31:0] e_wd, input int rdy_dly, input int rv_dly,
                         input logic [31:0] rdata, input bit chk_rd, input logic [31:0] e_rd);
        logic [36:0] exp_f;
        int waited;
        exp_f = {e_we, e_addr, e_be};
        @(negedge i_clk);
        chk({tag, "/grant_latency"}, 96'(o_bus_valid), 96'(1));
        waited = 0;
        while (!o_bus_valid && waited < 8) begin
            @(negedge i_clk);
            waited++;
        end
        if (!o_bus_valid) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s/grant_timeout: bus_valid 0 after 8 cycles, want 1", tag);
            return;
        end
        chk({tag, "/fields"}, 96'({o_bus_we, o_bus_addr, o_bus_be}), 96'(exp_f));
        if (chk_wd) chk({tag, "/wdata"}, 96'(o_bus_wdata), 96'(e_wd));
        for (int k = 0; k <= rdy_dly; k++) begin
            i_bus_ready  = (k == rdy_dly);
            i_bus_rvalid = 1'($urandom_range(0, 1));
            i_bus_rdata  = $urandom;
            #1;
            chk({tag, "/no_strobe_req"}, 96'({o_if_rvalid, o_dm_done}), 96'(0));
            chk({tag, "/stall_req"}, 96'({o_stall_if, o_stall_mem}), 96'({i_if_req, i_dm_req}));
            @(negedge i_clk);
            if (k < rdy_dly)
                chk({tag, "/req_hold"}, 96'({o_bus_valid, o_bus_we, o_bus_addr, o_bus_be}),
                    96'({1'b1, exp_f}));
        end
        i_bus_ready  = 1'b0;
        i_bus_rvalid = 1'b0;
        #1;
        chk({tag, "/valid_drop"}, 96'(o_bus_valid), 96'(0));
        for (int k = 0; k <= rv_dly; k++) begin
            i_bus_rvalid = (k == rv_dly);
            i_bus_rdata  = (k == rv_dly) ? rdata : $urandom;
            #1;
            if (k < rv_dly) begin
                chk({tag, "/no_strobe_resp"}, 96'({o_if_rvalid, o_dm_done}), 96'(0));
            end else begin
                chk({tag, "/strobe"}, 96'({o_if_rvalid, o_dm_done}),
                    exp_dm ? 96'(2'b01) : 96'(2'b10));
                chk({tag, "/stall_resp"}, 96'({o_stall_if, o_stall_mem}),
                    96'({i_if_req & exp_dm, i_dm_req & ~exp_dm}));
                if (chk_rd)
                    chk({tag, "/rdata"}, 96'(exp_dm ? o_dm_rdata : o_if_rdata), 96'(e_rd));
            end
            @(negedge i_clk);
        end
        i_bus_rvalid = 1'b0;
    endtask

    typedef struct {
        bit          is_dm;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bsel;
        logic [2:0]  f3;
        int          rdy;
        int          rv;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_raw;
        logic [31:0] exp_ext;
    } vec_t;

    vec_t vt[8];

    initial begin
        logic [31:0] a, rd, e_rd;
        logic [2:0]  f3;
        bit          exp_dm, we;
        int          streak;
        logic [2:0]  f3_tab[5];

        vt[0] = '{0, 0, 32'h0000_0100, 32'h0, 4'h0, 3'd0, 0, 0, 32'h0000_0013,
                  32'h0000_0100, 4'hF, 32'h0000_0013, 32'h0000_0013};
        vt[1] = '{1, 0, 32'h2000_0004, 32'h0, 4'h0, 3'b010, 1, 0, 32'hDEAD_BEEF,
                  32'h2000_0004, 4'hF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vt[2] = '{1, 1, 32'h3000_0000, 32'h00AB_0000, 4'b0100, 3'd0, 3, 1, 32'h1234_5678,
                  32'h3000_0000, 4'b0100, 32'h0, 32'h0};
        vt[3] = '{1, 0, 32'h4000_0003, 32'h0, 4'h0, 3'b000, 0, 0, 32'h80FF_FFFF,
                  32'h4000_0000, 4'hF, 32'h80FF_FFFF, 32'hFFFF_FF80};
        vt[4] = '{1, 0, 32'h4000_0003, 32'h0, 4'h0, 3'b100, 0, 1, 32'h80FF_FFFF,
                  32'h4000_0000, 4'hF, 32'h80FF_FFFF, 32'h0000_0080};
        vt[5] = '{1, 0, 32'h4000_0012, 32'h0, 4'h0, 3'b001, 0, 0, 32'h8001_1234,
                  32'h4000_0010, 4'hF, 32'h8001_1234, 32'hFFFF_8001};
        vt[6] = '{1, 0, 32'h4000_0012, 32'h0, 4'h0, 3'b101, 2, 0, 32'h8001_1234,
                  32'h4000_0010, 4'hF, 32'h8001_1234, 32'h0000_8001};
        vt[7] = '{0, 0, 32'h0000_0104, 32'h0, 4'h0, 3'd0, 2, 2, 32'h00A0_0093,
                  32'h0000_0104, 4'hF, 32'h00A0_0093, 32'h00A0_0093};
        f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        // Reset with a stray response present: nothing may come out.
        i_rstn = 1'b0; i_if_req = 1'b0; i_if_addr = '0; clear_dm();
        i_bus_ready = 1'b0; i_bus_rvalid = 1'b1; i_bus_rdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge i_clk);
        chk("reset/bus", 96'({o_bus_valid, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be}), 96'(0));
        chk("reset/strobes", 96'({o_if_rvalid, o_dm_done}), 96'(0));
        i_bus_rvalid = 1'b0;
        i_rstn = 1'b1;
        @(negedge i_clk);
        chk("idle/no_grant", 96'(o_bus_valid), 96'(0));

        // Directed table: one requester at a time.
        for (int i = 0; i < 8; i++) begin
`ifdef MEMARB_LOAD_EXT_EN
            e_rd = vt[i].is_dm ? vt[i].exp_ext : vt[i].exp_raw;
`else
            e_rd = vt[i].exp_raw;
`endif
            if (vt[i].is_dm) set_dm(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].bsel, vt[i].f3);
            else             set_fetch(vt[i].addr);
            serve($sformatf("vec%0d", i), vt[i].is_dm, vt[i].exp_addr, vt[i].we, vt[i].exp_be,
                  vt[i].we, vt[i].wdata, vt[i].rdy, vt[i].rv, vt[i].rdata, !vt[i].we, e_rd);
            if (vt[i].is_dm) clear_dm();
            else             i_if_req = 1'b0;
        end

        // Simultaneous fetch and load: data first, fetch granted at N+4.
        set_fetch(32'h0000_0200);
        set_dm(1'b0, 32'h0000_0400, 32'h0, 4'h0, 3'b010);
        serve("simul/dm", 1, 32'h0000_0400, 0, 4'hF, 0, 0, 0, 0, 32'h1111_2222, 1,
              exp_load(32'h1111_2222, 2'd0, 3'b010));
        clear_dm();
        serve("simul/if", 0, 32'h0000_0200, 0, 4'hF, 0, 0, 0, 0, 32'h3333_4444, 1, 32'h3333_4444);
        i_if_req = 1'b0;

        // Starvation: four data grants overtake the fetch, the fifth goes to fetch.
        set_fetch(32'h0000_0500);
        for (int g = 0; g < STARVE; g++) begin
            set_dm(1'b1, 32'h0000_0600 + 32'(4 * g), 32'hA5A5_0000 + 32'(g), 4'hF, 3'd0);
            serve($sformatf("starve/dm%0d", g), 1, 32'h0000_0600 + 32'(4 * g), 1, 4'hF, 1,
                  32'hA5A5_0000 + 32'(g), 0, 0, 32'h0, 0, 0);
        end
        set_dm(1'b1, 32'h0000_0700, 32'h5A5A_5A5A, 4'b0011, 3'd0);
        serve("starve/forced_if", 0, 32'h0000_0500, 0, 4'hF, 0, 0, 0, 0, 32'hCAFE_0001, 1,
              32'hCAFE_0001);
        set_fetch(32'h0000_0504);
        serve("starve/cleared", 1, 32'h0000_0700, 1, 4'b0011, 1, 32'h5A5A_5A5A, 0, 0, 0, 0, 0);
        clear_dm();
        serve("starve/if_after", 0, 32'h0000_0504, 0, 4'hF, 0, 0, 1, 0, 32'hCAFE_0002, 1,
              32'hCAFE_0002);
        i_if_req = 1'b0;

        // Reset while waiting for the response: ownership dropped, late rvalid ignored.
        set_dm(1'b0, 32'h0000_0800, 32'h0, 4'h0, 3'b010);
        @(negedge i_clk);
        chk("rst_resp/valid", 96'(o_bus_valid), 96'(1));
        i_bus_ready = 1'b1;
        @(negedge i_clk);
        i_bus_ready = 1'b0;
        i_rstn = 1'b0;
        #1;
        chk("rst_resp/bus", 96'({o_bus_valid, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be}), 96'(0));
        i_bus_rvalid = 1'b1;
        #1;
        chk("rst_resp/no_strobe", 96'({o_if_rvalid, o_dm_done}), 96'(0));
        @(negedge i_clk);
        clear_dm();
        i_rstn = 1'b1;
        #1;
        chk("rst_resp/late_rvalid", 96'({o_if_rvalid, o_dm_done}), 96'(0));
        @(negedge i_clk);
        chk("rst_resp/idle", 96'({o_bus_valid, o_if_rvalid, o_dm_done}), 96'(0));
        i_bus_rvalid = 1'b0;

        // Randomized traffic against the transaction model. The model tracks how many
        // data grants in a row have overtaken a waiting fetch.
        streak = 0;
        for (int t = 0; t < 200; t++) begin
            if (!i_if_req && $urandom_range(0, 2) != 0) begin
                a = $urandom;
                a[1:0] = 2'b00;
                set_fetch(a);
            end
            if (!i_dm_req && ($urandom_range(0, 2) != 0 || !i_if_req)) begin
                we = ($urandom_range(0, 2) == 0);
                a  = $urandom;
                if (we) begin
                    a[1:0] = 2'b00;
                    set_dm(1'b1, a, $urandom, 4'($urandom_range(1, 15)), 3'd0);
                end else begin
                    f3 = f3_tab[$urandom_range(0, 4)];
                    if (f3 == 3'b010) a[1:0] = 2'b00;
                    if (f3 == 3'b001 || f3 == 3'b101) a[0] = 1'b0;
                    set_dm(1'b0, a, 32'h0, 4'h0, f3);
                end
            end
            exp_dm = i_dm_req && !(i_if_req && streak >= STARVE);
            if (exp_dm && i_if_req) streak = streak + 1;
            else                    streak = 0;
            rd = $urandom;
            if (exp_dm) begin
                e_rd = exp_load(rd, i_dm_addr[1:0], i_dm_funct3);
                a    = i_dm_we ? i_dm_addr : (i_dm_addr & 32'hFFFF_FFFC);
                serve($sformatf("rnd%0d/dm", t), 1, a, i_dm_we, i_dm_we ? i_dm_byte_sel : 4'hF,
                      i_dm_we, i_dm_wdata, $urandom_range(0, 2), $urandom_range(0, 2), rd,
                      !i_dm_we, e_rd);
                clear_dm();
            end else begin
                serve($sformatf("rnd%0d/if", t), 0, i_if_addr, 0, 4'hF, 0, 0,
                      $urandom_range(0, 2), $urandom_range(0, 2), rd, 1, rd);
                i_if_req = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
